// File: rtl/mc_control_unit.sv
// Multicycle ARM-subset controller: decodes Instr, steps the FETCH..BRANCH FSM, owns NZCV flags.
// Latency FETCH->FETCH: LDR 5, STR/DP 4, B 3, undefined 2; no backpressure, advances every clock.
module mc_control_unit #(
    parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUflags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        ALUsrcA,
    output logic [1:0]  ALUsrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUcontrol,
    output logic [3:0]  FlagsQ,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_state;
    logic [3:0]  r_flags;
    logic        r_cx;

    logic [1:0]  w_op;
    logic        w_imm;
    logic        w_sbit;
    logic        w_rd_pc;
    logic [1:0]  w_alu_op;
    logic        w_dp_ok;
    logic        w_nowrite;
    logic        w_logic_op;
    logic        w_cond_ok;
    logic        w_flag_wr;
    logic        w_n, w_z, w_c, w_v;
    logic        w_unused;

    assign w_op    = Instr[27:26];
    assign w_imm   = Instr[25];
    assign w_sbit  = Instr[20];
    assign w_rd_pc = (Instr[15:12] == 4'hF);
    assign {w_c, w_v, w_n, w_z} = r_flags;
    assign w_unused = ^{Instr[19:16], Instr[11:0]};

    always_comb begin
        w_alu_op   = 2'b00;
        w_dp_ok    = 1'b1;
        w_nowrite  = 1'b0;
        w_logic_op = 1'b0;
        case (Instr[24:21])
            4'b0100: w_alu_op = 2'b00;
            4'b0010: w_alu_op = 2'b01;
            4'b0000: begin w_alu_op = 2'b10; w_logic_op = 1'b1; end
            4'b1100: begin w_alu_op = 2'b11; w_logic_op = 1'b1; end
            4'b1010: begin w_alu_op = 2'b01; w_nowrite = 1'b1; end
            default: w_dp_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_cond_ok = 1'b0;
        case (Instr[31:28])
            4'h0: w_cond_ok = w_z;
            4'h1: w_cond_ok = ~w_z;
            4'h2: w_cond_ok = w_c;
            4'h3: w_cond_ok = ~w_c;
            4'h4: w_cond_ok = w_n;
            4'h5: w_cond_ok = ~w_n;
            4'h6: w_cond_ok = w_v;
            4'h7: w_cond_ok = ~w_v;
            4'h8: w_cond_ok = w_c & ~w_z;
            4'h9: w_cond_ok = ~w_c | w_z;
            4'hA: w_cond_ok = (w_n == w_v);
            4'hB: w_cond_ok = (w_n != w_v);
            4'hC: w_cond_ok = ~w_z & (w_n == w_v);
            4'hD: w_cond_ok = w_z | (w_n != w_v);
            4'hE: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // CMP always updates flags; otherwise only S-suffixed forms do.
    assign w_flag_wr = r_cx & (w_sbit | w_nowrite);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_flags <= FLAGS_INIT;
            r_cx    <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    r_cx <= w_cond_ok;
                    case (w_op)
                        2'b00:   r_state <= !w_dp_ok ? S_FETCH : (w_imm ? S_EXECI : S_EXECR);
                        2'b01:   r_state <= S_MEMADR;
                        2'b10:   r_state <= S_BRANCH;
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  r_state <= w_sbit ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: r_state <= S_MEMWB;
                S_EXECR, S_EXECI: begin
                    r_state <= S_ALUWB;
                    if (w_flag_wr) begin
                        if (w_logic_op)
                            r_flags[1:0] <= ALUflags[1:0];
                        else
                            r_flags <= ALUflags;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // During reset the selects already look like FETCH so the first real cycle is clean.
    assign w_state = reset ? S_FETCH : r_state;
    assign State   = w_state;
    assign FlagsQ  = r_flags;
    assign ImmSrc  = w_op;
    assign RegSrc  = {(w_op == 2'b01) & ~w_sbit, (w_op == 2'b10)};

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ALUsrcA    = 1'b0;
        ALUsrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUcontrol = 2'b00;
        case (w_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUsrcA   = 1'b1;
                ALUsrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUsrcA   = 1'b1;
                ALUsrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:  ALUsrcB = 2'b01;
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = r_cx;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = r_cx;
                PCWrite   = r_cx & w_rd_pc;
            end
            S_EXECR: ALUcontrol = w_alu_op;
            S_EXECI: begin
                ALUsrcB    = 2'b01;
                ALUcontrol = w_alu_op;
            end
            S_ALUWB: begin
                RegWrite = r_cx & ~w_nowrite;
                PCWrite  = r_cx & ~w_nowrite & w_rd_pc;
            end
            S_BRANCH: begin
                ALUsrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = r_cx;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-cycle expected control words are queued per instruction
// and popped against the DUT each cycle; flag and reset behaviour is checked inline.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUflags;
    logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUsrcA;
    logic [1:0]  ALUsrcB, ResultSrc, ImmSrc, RegSrc, ALUcontrol;
    logic [3:0]  FlagsQ, State;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, adr, mw, rw, sa;
        logic [1:0] sb, res, alu, rs, imm;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [1:0] g_rs, g_imm;

    mc_control_unit #(.FLAGS_INIT(4'b0000)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUflags(ALUflags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUcontrol(ALUcontrol), .FlagsQ(FlagsQ),
        .State(State)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_exp(input logic [3:0] st, input logic pcw, irw, adr, mw, rw, sa,
                            input logic [1:0] sb, res, alu);
        exp_t e;
        e.st = st; e.pcw = pcw; e.irw = irw; e.adr = adr; e.mw = mw; e.rw = rw; e.sa = sa;
        e.sb = sb; e.res = res; e.alu = alu; e.rs = g_rs; e.imm = g_imm;
        exp_q.push_back(e);
    endtask

    task automatic p_fetch();               push_exp(4'd0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00); endtask
    task automatic p_decode();              push_exp(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00); endtask
    task automatic p_memadr();              push_exp(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00); endtask
    task automatic p_memread();             push_exp(4'd3, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00); endtask
    task automatic p_memwb(input logic rw); push_exp(4'd4, 0, 0, 0, 0, rw, 0, 2'b00, 2'b01, 2'b00); endtask
    task automatic p_memwr(input logic mw); push_exp(4'd5, 0, 0, 1, mw, 0, 0, 2'b00, 2'b00, 2'b00); endtask
    task automatic p_branch(input logic pcw); push_exp(4'd9, pcw, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00); endtask

    // Drive one instruction from its FETCH cycle and drain n queued cycle expectations.
    task automatic run(input logic [31:0] ins, input logic [3:0] fl, input int n);
        exp_t e, a;
        Instr = ins;
        ALUflags = fl;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            a = {State, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUsrcA,
                 ALUsrcB, ResultSrc, ALUcontrol, RegSrc, ImmSrc};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty instr=%h step=%0d actual=%h required=queued entry", ins, k, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e)
                    $display("FAIL cycle instr=%h step=%0d state=%0d actual=%h required=%h", ins, k, State, a, e);
                else
                    n_pass++;
            end
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_leftover instr=%h entries=%0d required=0", ins, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Data-processing instruction: FETCH, DECODE, EXECR(6)/EXECI(7), ALUWB.
    task automatic dp(input logic [31:0] ins, input logic [3:0] fl, input logic [3:0] ex_st,
                      input logic [1:0] alu, input logic rw, input logic pcw);
        g_rs = 2'b00; g_imm = 2'b00;
        p_fetch(); p_decode();
        push_exp(ex_st, 0, 0, 0, 0, 0, 0, (ex_st == 4'd7) ? 2'b01 : 2'b00, 2'b00, alu);
        push_exp(4'd8, pcw, 0, 0, 0, rw, 0, 2'b00, 2'b00, 2'b00);
        run(ins, fl, 4);
    endtask

    task automatic test_reset();
        reset = 1'b1; Instr = 32'h0; ALUflags = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (State !== 4'd0) $display("FAIL reset_state actual=%0d required=0", State); else n_pass++;
        n_checks++;
        if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000)
            $display("FAIL reset_enables actual=%b required=0000", {PCWrite, IRWrite, MemWrite, RegWrite});
        else n_pass++;
        n_checks++;
        if (FlagsQ !== 4'b0000) $display("FAIL reset_flags actual=%b required=0000", FlagsQ); else n_pass++;
        n_checks++;
        if ({ALUsrcA, ALUsrcB, ResultSrc, ALUcontrol} !== 7'b1101000)
            $display("FAIL reset_selects actual=%b required=1101000", {ALUsrcA, ALUsrcB, ResultSrc, ALUcontrol});
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_add_imm();
        dp(32'hE2821005, 4'b1111, 4'd7, 2'b00, 1, 0);
        n_checks++;
        if (FlagsQ !== 4'b0000) $display("FAIL add_no_flags actual=%b required=0000", FlagsQ); else n_pass++;
    endtask

    task automatic test_cond_exec();
        dp(32'hE0521003, 4'b0001, 4'd6, 2'b01, 1, 0);
        n_checks++;
        if (FlagsQ !== 4'b0001) $display("FAIL subs_flags actual=%b required=0001", FlagsQ); else n_pass++;
        dp(32'h02821005, 4'b0000, 4'd7, 2'b00, 1, 0);
        dp(32'h12821005, 4'b0000, 4'd7, 2'b00, 0, 0);
    endtask

    task automatic test_flags();
        dp(32'hE1520003, 4'b0011, 4'd6, 2'b01, 0, 0);
        n_checks++;
        if (FlagsQ !== 4'b0011) $display("FAIL cmp_flags actual=%b required=0011", FlagsQ); else n_pass++;
        dp(32'hE0121003, 4'b1100, 4'd6, 2'b10, 1, 0);
        n_checks++;
        if (FlagsQ !== 4'b0000) $display("FAIL ands_flags actual=%b required=0000", FlagsQ); else n_pass++;
        dp(32'hE2921005, 4'b1010, 4'd7, 2'b00, 1, 0);
        n_checks++;
        if (FlagsQ !== 4'b1010) $display("FAIL adds_flags actual=%b required=1010", FlagsQ); else n_pass++;
        dp(32'hE1921003, 4'b0101, 4'd6, 2'b11, 1, 0);
        n_checks++;
        if (FlagsQ !== 4'b1001) $display("FAIL orrs_flags actual=%b required=1001", FlagsQ); else n_pass++;
        dp(32'h10521003, 4'b0110, 4'd6, 2'b01, 0, 0);
        n_checks++;
        if (FlagsQ !== 4'b1001) $display("FAIL subsne_flags actual=%b required=1001", FlagsQ); else n_pass++;
        // Clears Z during its own execute; writeback must still use the DECODE-time condition.
        dp(32'h00521003, 4'b0000, 4'd6, 2'b01, 1, 0);
        n_checks++;
        if (FlagsQ !== 4'b0000) $display("FAIL subseq_flags actual=%b required=0000", FlagsQ); else n_pass++;
    endtask

    task automatic test_mem();
        g_rs = 2'b00; g_imm = 2'b01;
        p_fetch(); p_decode(); p_memadr(); p_memread(); p_memwb(1);
        run(32'hE5912004, 4'b1111, 5);
        g_rs = 2'b10; g_imm = 2'b01;
        p_fetch(); p_decode(); p_memadr(); p_memwr(1);
        run(32'hE5812004, 4'b1111, 4);
        n_checks++;
        if (FlagsQ !== 4'b0000) $display("FAIL mem_flags actual=%b required=0000", FlagsQ); else n_pass++;
    endtask

    task automatic test_branch();
        g_rs = 2'b01; g_imm = 2'b10;
        p_fetch(); p_decode(); p_branch(0);
        run(32'h0A000002, 4'b0000, 3);
        dp(32'hE1520003, 4'b0001, 4'd6, 2'b01, 0, 0);
        g_rs = 2'b01; g_imm = 2'b10;
        p_fetch(); p_decode(); p_branch(1);
        run(32'h0A000002, 4'b0000, 3);
    endtask

    task automatic test_undefined();
        g_rs = 2'b00; g_imm = 2'b11;
        p_fetch(); p_decode();
        run(32'hEC000000, 4'b1111, 2);
        g_rs = 2'b00; g_imm = 2'b00;
        p_fetch(); p_decode();
        run(32'hE0321003, 4'b1111, 2);
        n_checks++;
        if (FlagsQ !== 4'b0001) $display("FAIL undef_flags actual=%b required=0001", FlagsQ); else n_pass++;
    endtask

    task automatic test_pc_dest();
        dp(32'hE282F005, 4'b0000, 4'd7, 2'b00, 1, 1);
    endtask

    task automatic test_reset_midinstr();
        g_rs = 2'b10; g_imm = 2'b01;
        p_fetch(); p_decode(); p_memadr();
        run(32'hE5812004, 4'b0000, 3);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (MemWrite !== 1'b0) $display("FAIL rst_memwrite actual=%b required=0", MemWrite); else n_pass++;
        n_checks++;
        if (State !== 4'd0) $display("FAIL rst_state_now actual=%0d required=0", State); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (State !== 4'd0) $display("FAIL rst_state_next actual=%0d required=0", State); else n_pass++;
        n_checks++;
        if (FlagsQ !== 4'b0000) $display("FAIL rst_flags actual=%b required=0000", FlagsQ); else n_pass++;
        n_checks++;
        if ({PCWrite, IRWrite, RegWrite} !== 3'b000)
            $display("FAIL rst_enables actual=%b required=000", {PCWrite, IRWrite, RegWrite});
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        dp(32'hE2821005, 4'b0000, 4'd7, 2'b00, 1, 0);
        g_rs = 2'b00; g_imm = 2'b01;
        p_fetch(); p_decode(); p_memadr(); p_memread(); p_memwb(1);
        run(32'hE5912004, 4'b0000, 5);
        g_rs = 2'b01; g_imm = 2'b10;
        p_fetch(); p_decode(); p_branch(1);
        run(32'hEA000002, 4'b0000, 3);
    endtask

    initial begin
        g_rs = 2'b00;
        g_imm = 2'b00;
        test_reset();
        test_add_imm();
        test_cond_exec();
        test_flags();
        test_mem();
        test_branch();
        test_undefined();
        test_pc_dest();
        test_reset_midinstr();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
